// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider (div, div_step).
// Optional feature macro: DIV_FAST_PATH_EN (early finish when |dividend| < |divisor|).
package div_pkg;

  localparam int unsigned DIV_WIDTH    = 32;
  localparam int unsigned DIV_ITER_CNT = DIV_WIDTH;
  localparam int unsigned DIV_CNT_W    = $clog2(DIV_ITER_CNT + 1);

  typedef logic [DIV_WIDTH-1:0] reg_data_t;
  typedef logic                 reset_status_t;

  localparam reset_status_t RST_ENABLE = 1'b0;
  localparam reg_data_t     REG_ZERO   = {DIV_WIDTH{1'b0}};
  localparam reg_data_t     REG_ONE    = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_t;

  // Two's complement negation of one operand word.
  function automatic reg_data_t neg_word(input reg_data_t v);
    return (~v) + REG_ONE;
  endfunction

  // Magnitude of an operand; unsigned operands pass through unchanged.
  function automatic reg_data_t mag_word(input reg_data_t v, input logic is_signed);
    reg_data_t r;
    if (is_signed && v[DIV_WIDTH-1]) begin
      r = neg_word(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
module div_step
  import div_pkg::*;
(
  input  reg_data_t rem_i,
  input  logic      bit_i,
  input  reg_data_t divisor_i,
  output reg_data_t rem_o,
  output logic      q_o
);

  logic [DIV_WIDTH:0] trial_s;

  // Trial subtraction; the partial remainder always stays below the divisor,
  // so the difference fits in one word when the subtraction is taken.
  always_comb begin
    trial_s = {rem_i, bit_i};
    if (trial_s >= {1'b0, divisor_i}) begin
      rem_o = trial_s[DIV_WIDTH-1:0] - divisor_i;
      q_o   = 1'b1;
    end else begin
      rem_o = trial_s[DIV_WIDTH-1:0];
      q_o   = 1'b0;
    end
  end

endmodule

// File: rtl/div.sv
// Multi-cycle signed/unsigned divider for the EX stage: {remainder, quotient}.
// Latency counted in rising edges including the start edge: WIDTH+1 normally,
// 2 for a zero divisor. Optional macro DIV_FAST_PATH_EN finishes in 1 edge
// when |dividend| < |divisor|; results are identical with or without it.
module div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  reset_status_t      rst,
  input  logic               signed_div_i,
  input  reg_data_t          opdata1_i,
  input  reg_data_t          opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [DIV_CNT_W-1:0] CNT_ZERO = {DIV_CNT_W{1'b0}};
  localparam logic [DIV_CNT_W-1:0] CNT_ONE  = {{(DIV_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_ITER_CNT - 1);

  div_state_t            state_q, state_d;
  logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
  reg_data_t             rem_q, rem_d;     // partial remainder
  reg_data_t             dvd_q, dvd_d;     // dividend bits shifting out, quotient bits shifting in
  reg_data_t             dsr_q, dsr_d;     // divisor magnitude
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]    result_q, result_d;
  logic                  ready_q, ready_d;

  reg_data_t             mag1_s, mag2_s;
  logic                  load_s;
  logic                  by_zero_s;
  logic                  fast_s;
  reg_data_t             step_rem_s;
  logic                  step_q_s;
  reg_data_t             quo_fin_s, rem_fin_s;

  div_step u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DIV_WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // Operand magnitudes and load qualifiers seen in DIV_FREE.
  always_comb begin
    mag1_s    = mag_word(opdata1_i, signed_div_i);
    mag2_s    = mag_word(opdata2_i, signed_div_i);
    load_s    = start_i && !annul_i;
    by_zero_s = (opdata2_i == REG_ZERO);
`ifdef DIV_FAST_PATH_EN
    fast_s    = !by_zero_s && (mag1_s < mag2_s);
`else
    fast_s    = 1'b0;
`endif
  end

  // Final quotient/remainder with sign correction from the last iteration.
  always_comb begin
    quo_fin_s = {dvd_q[DIV_WIDTH-2:0], step_q_s};
    rem_fin_s = step_rem_s;
    if (neg_quo_q) begin
      quo_fin_s = neg_word(quo_fin_s);
    end else begin
      quo_fin_s = {dvd_q[DIV_WIDTH-2:0], step_q_s};
    end
    if (neg_rem_q) begin
      rem_fin_s = neg_word(rem_fin_s);
    end else begin
      rem_fin_s = step_rem_s;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DIV_FREE;
      cnt_q     <= CNT_ZERO;
      rem_q     <= REG_ZERO;
      dvd_q     <= REG_ZERO;
      dsr_q     <= REG_ZERO;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE: begin
        if (load_s) begin
          if (by_zero_s) begin
            state_d = DIV_BY_ZERO;
          end else if (fast_s) begin
            state_d = DIV_END;
          end else begin
            state_d = DIV_ON;
          end
        end else begin
          state_d = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d = DIV_END;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DIV_END;
        end else begin
          state_d = DIV_ON;
        end
      end
      DIV_END: begin
        if (annul_i || !start_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d = DIV_END;
        end
      end
      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  // Datapath and output register updates for each state.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DIV_FREE: begin
        result_d = {(2*WIDTH){1'b0}};
        ready_d  = 1'b0;
        if (load_s) begin
          cnt_d     = CNT_ZERO;
          rem_d     = REG_ZERO;
          dvd_d     = mag1_s;
          dsr_d     = mag2_s;
          neg_quo_d = signed_div_i && (opdata1_i[DIV_WIDTH-1] ^ opdata2_i[DIV_WIDTH-1]);
          neg_rem_d = signed_div_i && opdata1_i[DIV_WIDTH-1];
          if (fast_s) begin
            // Quotient is zero and the remainder is the dividend as given.
            result_d = {opdata1_i, REG_ZERO};
            ready_d  = 1'b1;
          end else begin
            result_d = {(2*WIDTH){1'b0}};
            ready_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DIV_BY_ZERO: begin
        result_d = {(2*WIDTH){1'b0}};
        if (annul_i) begin
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          result_d = {(2*WIDTH){1'b0}};
          ready_d  = 1'b0;
        end else begin
          rem_d = step_rem_s;
          dvd_d = {dvd_q[DIV_WIDTH-2:0], step_q_s};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            result_d = {rem_fin_s, quo_fin_s};
            ready_d  = 1'b1;
          end else begin
            result_d = {(2*WIDTH){1'b0}};
            ready_d  = 1'b0;
          end
        end
      end
      DIV_END: begin
        if (annul_i || !start_i) begin
          result_d = {(2*WIDTH){1'b0}};
          ready_d  = 1'b0;
        end else begin
          result_d = result_q;
          ready_d  = 1'b1;
        end
      end
      default: begin
        result_d = {(2*WIDTH){1'b0}};
        ready_d  = 1'b0;
      end
    endcase
  end

  // Outputs come straight from their registers.
  always_comb begin
    result_o = result_q;
    ready_o  = ready_q;
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus random operands against an
// arithmetic reference model.
module tb_div;
  import div_pkg::*;

  logic          clk;
  reset_status_t rst;
  logic          signed_div_i;
  reg_data_t     opdata1_i;
  reg_data_t     opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [63:0]   result_o;
  logic          ready_o;

  int tests;
  int fails;

  div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic; {remainder, quotient} and edge latency.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int lat);
    longint sa, sb, q, r, ma, mb;
    logic [31:0] uq, ur;
    if (b == 32'd0) begin
      res = 64'd0;
      lat = 2;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        res = {r[31:0], q[31:0]};
        ma = (sa < 64'sd0) ? -sa : sa;
        mb = (sb < 64'sd0) ? -sb : sb;
      end else begin
        uq = a / b;
        ur = a % b;
        res = {ur, uq};
        ma = longint'({32'd0, a});
        mb = longint'({32'd0, b});
      end
      lat = 33;
`ifdef DIV_FAST_PATH_EN
      if (ma < mb) lat = 1;
`endif
    end
  endtask

  // Issue one division, hold start until ready, verify latency, result, hold and release.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp_res;
    int exp_lat;
    int n;
    model(s, a, b, exp_res, exp_lat);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_o === 1'b1) break;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    // New operands while still held must not disturb the result.
    opdata1_i = ~a;
    opdata2_i = 32'd3;
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {63'd0, ready_o} ^ result_o, {63'd0, 1'b1} ^ exp_res);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_release"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  initial begin
    logic seen;
    tests = 0;
    fails = 0;
    rst = RST_ENABLE;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    start_i = 1'b0;
    annul_i = 1'b0;
    #12;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed cases.
    run_op("u100_7", 1'b0, 32'd100, 32'd7);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("divzero", 1'b0, 32'h0000_1234, 32'd0);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("u5_9", 1'b0, 32'd5, 32'd9);
    run_op("s_m5_9", 1'b1, 32'hFFFF_FFFB, 32'd9);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);

    // Annul at iteration 10: no ready, then a fresh 9 / 3.
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul_out", {63'd0, ready_o} | result_o, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    check("annul_no_ready", {63'd0, seen}, 64'd0);
    run_op("u9_3", 1'b0, 32'd9, 32'd3);

    // Annul out of DIV_END while start is still held.
    signed_div_i = 1'b0;
    opdata1_i = 32'd4;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("bz_ready", {63'd0, ready_o}, 64'd1);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    check("end_annul", {63'd0, ready_o} | result_o, 64'd0);
    @(posedge clk);
    #1;

    // Reset in mid-division discards it; next start accepted immediately.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = RST_ENABLE;
    #2;
    check("midreset_out", {63'd0, ready_o} | result_o, 64'd0);
    start_i = 1'b0;
    #2;
    rst = 1'b1;
    run_op("after_rst", 1'b0, 32'd1000, 32'd3);

    // Random operands.
    for (int i = 0; i < 20; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(1, 0));
      a = $urandom;
      case ($urandom_range(3, 0))
        0: b = 32'd0;
        1: b = $urandom_range(15, 1);
        2: b = a + 32'd1 + 32'($urandom_range(100, 0));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), s, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
